// File: rtl/instruction_fetch.sv
// LC-3b instruction fetch: reads words over the memory handshake into a one-entry
// prefetch buffer and hands them to the IR with a single-cycle load strobe.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  output logic        mem_read,
  output logic [15:0] mem_address,
  output logic        ir_load,
  output logic [15:0] ir_data,
  output logic [15:0] inst_pc,
  output logic [15:0] pc_out,
  output logic [1:0]  dbg_state
);

  // Handshake: a read is issued while mem_read=1 with mem_address held stable; it
  // completes in the cycle mem_resp=1 and is never abandoned, even on redirect.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_fetch_pc;
  logic [15:0] r_req_addr;
  logic        r_buf_valid;
  logic [15:0] r_buf_data;
  logic [15:0] r_buf_pc;
  logic        r_ir_load;
  logic [15:0] r_ir_data;
  logic [15:0] r_inst_pc;
  logic [15:0] r_pc_out;

  state_t      w_state_nxt;
  logic [15:0] w_fetch_pc_nxt;
  logic [15:0] w_req_addr_nxt;
  logic        w_buf_valid_nxt;
  logic [15:0] w_buf_data_nxt;
  logic [15:0] w_buf_pc_nxt;
  logic        w_ir_load_nxt;
  logic [15:0] w_ir_data_nxt;
  logic [15:0] w_inst_pc_nxt;
  logic [15:0] w_pc_out_nxt;
  logic        w_consume;
  logic [15:0] w_redirect_pc;

  // The !r_ir_load term keeps a held fetch_req from delivering on back-to-back cycles.
  assign w_consume     = fetch_req & r_buf_valid & ~r_ir_load & ~redirect;
  assign w_redirect_pc = redirect_pc & 16'hFFFE;

  always_comb begin
    w_state_nxt     = r_state;
    w_fetch_pc_nxt  = r_fetch_pc;
    w_req_addr_nxt  = r_req_addr;
    w_buf_valid_nxt = r_buf_valid;
    w_buf_data_nxt  = r_buf_data;
    w_buf_pc_nxt    = r_buf_pc;
    w_ir_load_nxt   = 1'b0;
    w_ir_data_nxt   = r_ir_data;
    w_inst_pc_nxt   = r_inst_pc;
    w_pc_out_nxt    = r_pc_out;

    if (w_consume) begin
      w_ir_load_nxt   = 1'b1;
      w_ir_data_nxt   = r_buf_data;
      w_inst_pc_nxt   = r_buf_pc;
      w_pc_out_nxt    = r_buf_pc + 16'd2;
      w_buf_valid_nxt = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (redirect) begin
          w_fetch_pc_nxt = w_redirect_pc;
        end else if (!r_buf_valid || w_consume) begin
          w_req_addr_nxt = r_fetch_pc;
          w_state_nxt    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (mem_resp && !redirect) begin
          w_buf_data_nxt  = mem_rdata;
          w_buf_pc_nxt    = r_req_addr;
          w_buf_valid_nxt = 1'b1;
          w_fetch_pc_nxt  = r_fetch_pc + 16'd2;
          w_state_nxt     = S_IDLE;
        end else if (redirect) begin
          w_fetch_pc_nxt = w_redirect_pc;
          w_state_nxt    = mem_resp ? S_IDLE : S_DISCARD;
        end
      end
      S_DISCARD: begin
        // The read in flight belongs to the old path; only its completion matters.
        if (redirect) w_fetch_pc_nxt = w_redirect_pc;
        if (mem_resp) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (redirect) w_buf_valid_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_req_addr  <= RESET_PC;
      r_buf_valid <= 1'b0;
      r_buf_data  <= 16'h0000;
      r_buf_pc    <= 16'h0000;
      r_ir_load   <= 1'b0;
      r_ir_data   <= 16'h0000;
      r_inst_pc   <= 16'h0000;
      r_pc_out    <= RESET_PC;
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_req_addr  <= w_req_addr_nxt;
      r_buf_valid <= w_buf_valid_nxt;
      r_buf_data  <= w_buf_data_nxt;
      r_buf_pc    <= w_buf_pc_nxt;
      r_ir_load   <= w_ir_load_nxt;
      r_ir_data   <= w_ir_data_nxt;
      r_inst_pc   <= w_inst_pc_nxt;
      r_pc_out    <= w_pc_out_nxt;
    end
  end

  assign mem_read    = (r_state != S_IDLE);
  assign mem_address = r_req_addr;
  assign ir_load     = r_ir_load;
  assign ir_data     = r_ir_data;
  assign inst_pc     = r_inst_pc;
  assign pc_out      = r_pc_out;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: single-thread cycle stepper with a latency-programmable
// memory model and a scoreboard of expected IR deliveries {ir_data, inst_pc, pc_out}.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        mem_resp = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_read;
  logic [15:0] mem_address;
  logic        ir_load;
  logic [15:0] ir_data;
  logic [15:0] inst_pc;
  logic [15:0] pc_out;
  logic [1:0]  dbg_state;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          lat = 1;
  int          wait_cnt = 0;
  logic [15:0] held_addr = 16'h0000;
  logic        prev_load = 1'b0;
  logic [47:0] exp_q[$];

  instruction_fetch #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_resp    (mem_resp),
    .mem_rdata   (mem_rdata),
    .mem_read    (mem_read),
    .mem_address (mem_address),
    .ir_load     (ir_load),
    .ir_data     (ir_data),
    .inst_pc     (inst_pc),
    .pc_out      (pc_out),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: mem_word = 16'h1021;
      16'h0002: mem_word = 16'h5020;
      16'h0004: mem_word = 16'h0FFE;
      default:  mem_word = a ^ 16'hA5A5;
    endcase
  endfunction

  task automatic push_exp(input logic [15:0] pc, input logic [15:0] pc_next);
    exp_q.push_back({mem_word(pc), pc, pc_next});
  endtask

  // One cycle: sample at the falling edge, run the memory model and the delivery monitor.
  task automatic step();
    logic [47:0] e;
    @(negedge clk);
    cyc++;
    if (mem_read) begin
      if (wait_cnt == 0) held_addr = mem_address;
      else check("addr_stable", 48'(mem_address), 48'(held_addr));
      if (wait_cnt == lat - 1) begin
        mem_resp  = 1'b1;
        mem_rdata = mem_word(mem_address);
        wait_cnt  = 0;
      end else begin
        mem_resp  = 1'b0;
        mem_rdata = 16'h0000;
        wait_cnt++;
      end
    end else begin
      mem_resp  = 1'b0;
      mem_rdata = 16'h0000;
      wait_cnt  = 0;
    end
    if (ir_load) begin
      check("ir_gap", 48'(prev_load), 48'(0));
      check("sb_pending", 48'(exp_q.size() > 0), 48'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("deliver", {ir_data, inst_pc, pc_out}, e);
      end
    end
    prev_load = ir_load;
  endtask

  task automatic wait_load(input int max_cyc);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!ir_load && k < max_cyc);
    check("load_seen", 48'(ir_load), 48'(1));
  endtask

  task automatic wait_resp(input int max_cyc);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!mem_resp && k < max_cyc);
    check("resp_seen", 48'(mem_resp), 48'(1));
  endtask

  task automatic check_reset_vals();
    check("rst_ir_load", 48'(ir_load), 48'(0));
    check("rst_ir_data", 48'(ir_data), 48'(0));
    check("rst_inst_pc", 48'(inst_pc), 48'(0));
    check("rst_pc_out", 48'(pc_out), 48'(16'h0000));
    check("rst_mem_read", 48'(mem_read), 48'(0));
    check("rst_mem_addr", 48'(mem_address), 48'(16'h0000));
    check("rst_state", 48'(dbg_state), 48'(0));
  endtask

  // Leaves the bench in cycle 0: reset low, DUT in its reset state.
  task automatic do_reset();
    reset     = 1'b1;
    fetch_req = 1'b0;
    redirect  = 1'b0;
    step();
    step();
    check_reset_vals();
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic end_test(input string tag);
    fetch_req = 1'b0;
    redirect  = 1'b0;
    step();
    step();
    check(tag, 48'(exp_q.size()), 48'(0));
  endtask

  initial begin
    // Reset fetch: first read in cycle 1, delivery in cycle 3, next read at 0x0002.
    lat = 1;
    do_reset();
    fetch_req = 1'b1;
    push_exp(16'h0000, 16'h0002);
    step();
    check("c1_mem_read", 48'(mem_read), 48'(1));
    check("c1_mem_addr", 48'(mem_address), 48'(16'h0000));
    step();
    check("c2_no_load", 48'(ir_load), 48'(0));
    step();
    check("c3_load", 48'(ir_load), 48'(1));
    check("c3_next_read", 48'({mem_read, mem_address}), 48'({1'b1, 16'h0002}));
    step();
    check("c4_one_pulse", 48'(ir_load), 48'(0));
    end_test("t1_sb_empty");

    // Streaming three words with fetch_req held.
    do_reset();
    fetch_req = 1'b1;
    push_exp(16'h0000, 16'h0002);
    push_exp(16'h0002, 16'h0004);
    push_exp(16'h0004, 16'h0006);
    for (int i = 0; i < 3; i++) wait_load(20);
    end_test("t2_sb_empty");

    // Redirect in the second cycle of the read of 0x0002, latency 4.
    lat = 4;
    do_reset();
    fetch_req = 1'b1;
    push_exp(16'h0000, 16'h0002);
    push_exp(16'h3000, 16'h3002);
    begin
      int k;
      k = 0;
      do begin
        step();
        k++;
      end while (!(mem_read && mem_address == 16'h0002) && k < 30);
      check("t3_read2_seen", 48'(mem_address), 48'(16'h0002));
    end
    step();
    redirect    = 1'b1;
    redirect_pc = 16'h3001;
    step();
    redirect = 1'b0;
    check("t3_hold_read", 48'({mem_read, mem_address}), 48'({1'b1, 16'h0002}));
    wait_resp(10);
    step();
    check("t3_gap_idle", 48'(mem_read), 48'(0));
    step();
    check("t3_new_read", 48'({mem_read, mem_address}), 48'({1'b1, 16'h3000}));
    wait_load(20);
    end_test("t3_sb_empty");

    // Redirect coinciding with a would-be consume of a buffered word.
    lat = 1;
    do_reset();
    step();
    step();
    step();
    fetch_req   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h4000;
    step();
    redirect = 1'b0;
    check("t4_suppressed", 48'(ir_load), 48'(0));
    push_exp(16'h4000, 16'h4002);
    step();
    check("t4_redir_read", 48'({mem_read, mem_address}), 48'({1'b1, 16'h4000}));
    wait_load(20);
    end_test("t4_sb_empty");

    // Wrap at the top of the address space, redirect issued in cycle 0.
    lat = $urandom_range(3, 1);
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    push_exp(16'hFFFE, 16'h0000);
    step();
    redirect = 1'b0;
    check("t5_idle", 48'(mem_read), 48'(0));
    step();
    check("t5_read", 48'({mem_read, mem_address}), 48'({1'b1, 16'hFFFE}));
    fetch_req = 1'b1;
    wait_load(20);
    check("t5_wrap_read", 48'({mem_read, mem_address}), 48'({1'b1, 16'h0000}));
    end_test("t5_sb_empty");

    // Reset while in DISCARD, then a stale response while idle.
    lat = 6;
    do_reset();
    step();
    redirect    = 1'b1;
    redirect_pc = 16'h2000;
    step();
    redirect = 1'b0;
    check("t6_discard", 48'({mem_read, mem_address, dbg_state}), 48'({1'b1, 16'h0000, 2'd2}));
    reset = 1'b1;
    step();
    check_reset_vals();
    reset     = 1'b0;
    cyc       = 0;
    mem_resp  = 1'b1;
    mem_rdata = 16'hDEAD;
    lat       = 2;
    fetch_req = 1'b1;
    push_exp(16'h0000, 16'h0002);
    step();
    check("t6_restart", 48'({mem_read, mem_address}), 48'({1'b1, 16'h0000}));
    wait_load(20);
    end_test("t6_sb_empty");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit: the writer side of the instruction register. It reads 16-bit LC-3b instruction words from memory over the memory handshake and holds one prefetched word. On request from the control FSM it presents each word to the IR with a one-cycle load strobe. It tracks the fetch PC, including redirects from taken branches, JMP/JSR and TRAP.

## Interface

Parameters:
- RESET_PC, 16'h0000, fetch address after reset. Bit 0 must be 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_req  in  1  control wants the next instruction. Level signal, held until ir_load is seen.
- redirect  in  1  one-cycle pulse: flush and restart fetch at redirect_pc.
- redirect_pc  in  16  new fetch address. Bit 0 is forced to 0 internally.
- mem_resp  in  1  memory has completed the current read.
- mem_rdata  in  16  read data, valid while mem_resp=1.
- mem_read  out  1  memory read request.
- mem_address  out  16  read address. Stable while mem_read=1.
- ir_load  out  1  one-cycle strobe; connects to the IR load input.
- ir_data  out  16  instruction word; connects to the IR data input.
- inst_pc  out  16  address of the word on ir_data.
- pc_out  out  16  inst_pc + 2, the LC-3b incremented PC.

## Operation

- Registers:
  - fetch_pc: next address to fetch.
  - req_addr: drives mem_address.
  - One-entry buffer: buf_valid, buf_data, buf_pc.
  - Registered outputs: ir_load, ir_data, inst_pc, pc_out.
- States: IDLE, FETCH, DISCARD.
  - mem_read = 1 in FETCH and DISCARD, 0 in IDLE.
- consume = fetch_req & buf_valid & !ir_load & !redirect.
- On consume:
  - ir_load <= 1, ir_data <= buf_data, inst_pc <= buf_pc, pc_out <= buf_pc + 2.
  - buf_valid <= 0.
  - In every other cycle ir_load <= 0. ir_data, inst_pc and pc_out hold their values.
- IDLE:
  - If redirect: fetch_pc <= redirect_pc, buf_valid <= 0, stay IDLE.
  - Else if buf_valid=0 or consume: req_addr <= fetch_pc, go FETCH.
- FETCH:
  - mem_resp & !redirect: buf_data <= mem_rdata, buf_pc <= req_addr, buf_valid <= 1, fetch_pc <= fetch_pc + 2, go IDLE.
  - redirect & mem_resp: discard the data, fetch_pc <= redirect_pc, go IDLE.
  - redirect & !mem_resp: fetch_pc <= redirect_pc, go DISCARD. mem_read and mem_address stay unchanged; a read is never abandoned.
- DISCARD:
  - On mem_resp: discard the data, go IDLE.
  - A further redirect updates fetch_pc only.
- Priority: redirect over consume over buffer fill.
  - A redirect in the same cycle as a would-be consume suppresses ir_load.
- Arithmetic: PC increments are 16-bit modulo. 16'hFFFE + 2 = 16'h0000, with no flag.
- Only a buffered word is delivered. There is no mem_rdata-to-ir_data bypass.
- Reset, in any state, including mid-read:
  - State IDLE, buf_valid 0, fetch_pc RESET_PC, req_addr RESET_PC.
  - ir_load 0, ir_data 0, inst_pc 0, pc_out RESET_PC, mem_read 0, mem_address RESET_PC.
  - An outstanding read is dropped; a stale mem_resp arriving in IDLE is ignored.

## Timing

- Cycle 0 is the first cycle with reset low: state IDLE. mem_read first rises in cycle 1.
- Fill: mem_resp high in cycle N gives buf_valid=1 in cycle N+1.
- Delivery: with fetch_req high, ir_load is high in cycle N+2.
  - The next fetch starts the same cycle (mem_read high in N+2).
- Buffered hit: fetch_req rising in cycle K with buf_valid=1 gives ir_load in cycle K+1.
- Consecutive ir_load pulses are at least 2 cycles apart, so a held fetch_req never double-delivers.
- Redirect latency: redirect in cycle R from IDLE puts mem_read at redirect_pc in cycle R+2.
  - From FETCH or DISCARD, the new read starts 2 cycles after the pending mem_resp.
- Memory may hold mem_resp low any number of cycles; mem_address must not change meanwhile.

## Test plan

- Reset fetch:
  - Stimulus: RESET_PC=16'h0000, memory 1-cycle latency, word 0x1021 at 0x0000, fetch_req held high.
  - Response: mem_read high in cycle 1 at 0x0000; ir_load high exactly one cycle with ir_data=0x1021, inst_pc=0x0000, pc_out=0x0002; next read at 0x0002.
- Streaming:
  - Stimulus: words 0x1021, 0x5020, 0x0FFE at 0x0000, 0x0002 and 0x0004; fetch_req held.
  - Response: three ir_load pulses in order, each separated by at least 2 cycles; inst_pc 0x0000, 0x0002, 0x0004.
- Redirect mid-read:
  - Stimulus: memory latency 4; redirect to 0x3001 in the second cycle of the read of 0x0002.
  - Response: mem_address stays 0x0002 until mem_resp, and that data is never loaded; next read at 0x3000; the next delivery has inst_pc=0x3000.
- Redirect vs consume:
  - Stimulus: buf_valid=1, fetch_req and redirect high in the same cycle.
  - Response: no ir_load; the buffer is flushed.
- Wrap:
  - Stimulus: redirect to 0xFFFE.
  - Response: delivered inst_pc=0xFFFE with pc_out=0x0000; next read at 0x0000.
- Reset mid-operation:
  - Stimulus: assert reset while in DISCARD.
  - Response: all outputs at their reset values the next cycle; a late mem_resp is ignored; fetching restarts at RESET_PC.
